reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the team's 12x8 register file: two registered read ports, one general write port and one dedicated carry/special-register write port.
- Adds synchronous reset of the whole array and same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard with busy flags, so the decode stage can stall on multi-cycle producers.
- Sits between decode (addresses, read enable, busy check) and writeback (wr/car ports).

Parameters:
- NUM_REGS, 12, number of architectural registers; register 0 is hardwired to zero.
- REG_WIDTH, 8, bits per register.
- CAR_IDX, 11, index of the carry/special register; legal range 1..NUM_REGS-1.
- ADDR_W (localparam), $clog2(NUM_REGS), address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- rd_en  in  1  read enable; captures both read ports this edge.
- rs_addr  in  ADDR_W  read port S address.
- rt_addr  in  ADDR_W  read port T address.
- rs_out  out  REG_WIDTH  registered read data, port S.
- rt_out  out  REG_WIDTH  registered read data, port T.
- wr_en  in  1  general write enable.
- wr_addr  in  ADDR_W  general write address.
- wr_data  in  REG_WIDTH  general write data.
- car_wr  in  1  special-register write enable.
- car_data  in  REG_WIDTH  special-register write data.
- car_out  out  REG_WIDTH  registered copy of regs[CAR_IDX], updated every cycle.
- pend_set  in  1  mark pend_addr as awaiting a write.
- pend_addr  in  ADDR_W  scoreboard set address.
- rs_busy  out  1  combinational: rs_addr register pending and not being written this cycle.
- rt_busy  out  1  combinational: same for rt_addr.

Behaviour:
- Clock and reset: single clock, synchronous active-low reset (rst_n).
- Reset (rst_n=0 at edge): all registers, rs_out, rt_out and car_out are cleared to 0, and all pending bits are cleared. Reset overrides every other input that cycle.
- Reads: 1-cycle latency.
  - On an edge with rd_en=1, rs_out and rt_out load the effective value of their address.
  - With rd_en=0 both outputs hold.
- Effective value, in priority order:
  1. Address 0 or address >= NUM_REGS gives 0.
  2. car_wr=1 and addr==CAR_IDX gives car_data.
  3. wr_en=1 and wr_addr==addr gives wr_data.
  4. Otherwise the stored regs[addr].
- Bypass: a read in the same cycle as a write therefore returns the new data.
- General write: regs[wr_addr] <= wr_data when wr_en=1.
  - Ignored for wr_addr=0 and wr_addr >= NUM_REGS.
- Special write: regs[CAR_IDX] <= car_data when car_wr=1.
  - If car_wr and a general write both target CAR_IDX in the same cycle, car_data wins.
- car_out: loads the effective value of CAR_IDX every cycle, regardless of rd_en.
- Scoreboard: one pending bit per register; bit 0 is never set.
  - pend_set=1 sets pending[pend_addr].
  - Any committed write clears the pending bit of the written address: a general write to a legal non-zero address, or car_wr for CAR_IDX.
  - A write and a pend_set to the same address in the same cycle leave the bit set (the new producer wins).
  - pend_set to address 0 or an out-of-range address is ignored.
- Busy flags:
  - rs_busy = pending[rs_addr] AND NOT (a committed write to rs_addr this cycle). rt_busy is the same for rt_addr.
  - Out-of-range addresses and address 0 are never busy.
  - The busy flags do not block reads or writes; stalling is the consumer's responsibility.
- Reset mid-operation: pending writes are discarded, with no carry-over.

Test Plan:
- Reset then read: rst_n=0 for one cycle, then rd_en=1 with rs=3, rt=11 → rs_out=0, rt_out=0, car_out=0, rs_busy=rt_busy=0.
- Write then read: write wr_addr=5, wr_data=0xA5; next cycle rd_en with rs=5 → rs_out=0xA5 one edge later. Write 0x3C to addr 0, then read 0 → 0x00.
- Same-cycle bypass: wr_en with addr 7, data 0x5A, together with rd_en and rs=rt=7 → both outputs 0x5A at that edge. rd_en=0 on the next cycle → outputs hold 0x5A.
- Special-register conflict: wr_en to addr 11 with 0x11, and car_wr with 0x22, in the same cycle → regs[11]=0x22. car_out=0x22 at that edge; a read of 11 returns 0x22.
- Scoreboard: pend_set addr 4, then rs=4 → rs_busy=1. Next, wr_en addr 4 with 0x77 → rs_busy=0 combinationally that cycle, and pending is cleared after the edge. pend_set together with a write to addr 4 → still busy. pend_set addr 0 → never busy.
- Reset mid-operation: with pending[4]=1 and regs[4]=0x77, pulse rst_n=0 → pending cleared, regs[4]=0, outputs 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two registered read ports,
// a general write port, a dedicated carry/special-register write port,
// same-cycle write-to-read bypass and a per-register pending-write scoreboard.
// Register 0 reads as zero and is never written or marked pending.
module reg_file_sb #(
    parameter int NUM_REGS  = 12,
    parameter int REG_WIDTH = 8,
    parameter int CAR_IDX   = 11,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [REG_WIDTH-1:0] rs_out,
    output logic [REG_WIDTH-1:0] rt_out,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [REG_WIDTH-1:0] wr_data,
    input  logic                 car_wr,
    input  logic [REG_WIDTH-1:0] car_data,
    output logic [REG_WIDTH-1:0] car_out,
    input  logic                 pend_set,
    input  logic [ADDR_W-1:0]    pend_addr,
    output logic                 rs_busy,
    output logic                 rt_busy
);

    // One extra bit so the range check also works when NUM_REGS is a power of two.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
    logic [REG_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  pend_q;
    logic [NUM_REGS-1:0]  pend_d;
    logic [NUM_REGS-1:0]  wr_hit;
    logic [REG_WIDTH-1:0] rs_q, rs_d;
    logic [REG_WIDTH-1:0] rt_q, rt_d;
    logic [REG_WIDTH-1:0] car_q, car_d;
    logic                 wr_commit;
    logic [REG_WIDTH-1:0] rs_eff;
    logic [REG_WIDTH-1:0] rt_eff;

    // Next array contents: general write first, special write overrides it, so
    // regs_d doubles as the bypassed "effective value" of every register.
    always_comb begin
        wr_commit = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < NUM_REGS_W);
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            wr_hit[i] = 1'b0;
            if (i != 0) begin
                if (wr_commit && (wr_addr == ADDR_W'(i))) begin
                    regs_d[i] = wr_data;
                    wr_hit[i] = 1'b1;
                end
                if (car_wr && (i == CAR_IDX)) begin
                    regs_d[i] = car_data;
                    wr_hit[i] = 1'b1;
                end
            end
        end
    end

    // Scoreboard update: a commit clears, a same-cycle pend_set re-arms the bit.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i] && !wr_hit[i];
            if (pend_set && (i != 0) && (pend_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    // Read-port lookup and busy flags; out-of-range addresses match no entry.
    always_comb begin
        rs_eff  = '0;
        rt_eff  = '0;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs_addr == ADDR_W'(i)) begin
                rs_eff  = regs_d[i];
                rs_busy = pend_q[i] && !wr_hit[i];
            end
            if (rt_addr == ADDR_W'(i)) begin
                rt_eff  = regs_d[i];
                rt_busy = pend_q[i] && !wr_hit[i];
            end
        end
        rs_d  = rd_en ? rs_eff : rs_q;
        rt_d  = rd_en ? rt_eff : rt_q;
        car_d = regs_d[CAR_IDX];
    end

    // State registers with synchronous active-low reset of everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            car_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            car_q  <= car_d;
        end
    end

    assign rs_out  = rs_q;
    assign rt_out  = rt_q;
    assign car_out = car_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scenarios from the test plan plus randomized
// traffic, checked against a behavioural model of the register file.
module tb_reg_file_sb;

  localparam int NR  = 12;
  localparam int W   = 8;
  localparam int CAR = 11;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] rs_addr, rt_addr;
  logic [W-1:0]  rs_out, rt_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          car_wr;
  logic [W-1:0]  car_data;
  logic [W-1:0]  car_out;
  logic          pend_set;
  logic [AW-1:0] pend_addr;
  logic          rs_busy, rt_busy;

  int checks = 0;
  int errors = 0;

  // model state
  logic [W-1:0] mem [NR];
  bit           pend [NR];
  logic [W-1:0] exp_rs = '0, exp_rt = '0, exp_car = '0;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_out(rs_out), .rt_out(rt_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .car_wr(car_wr), .car_data(car_data), .car_out(car_out),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy)
  );

  always #5 clk = ~clk;

  function automatic bit legal(int a);
    return (a >= 1) && (a < NR);
  endfunction

  function automatic bit written(int a);
    if (!legal(a)) return 0;
    if (car_wr && a == CAR) return 1;
    return wr_en && (int'(wr_addr) == a);
  endfunction

  function automatic logic [W-1:0] eff(int a);
    if (!legal(a)) return '0;
    if (car_wr && a == CAR) return car_data;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return mem[a];
  endfunction

  function automatic bit busy_m(int a);
    return legal(a) && pend[a] && !written(a);
  endfunction

  // Advance one clock edge and apply the specification's rules to the model.
  task automatic step();
    logic [W-1:0] n_rs, n_rt, n_car;
    bit           wrote [NR];
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin mem[i] = '0; pend[i] = 0; end
      exp_rs = '0; exp_rt = '0; exp_car = '0;
    end else begin
      n_rs  = rd_en ? eff(int'(rs_addr)) : exp_rs;
      n_rt  = rd_en ? eff(int'(rt_addr)) : exp_rt;
      n_car = eff(CAR);
      for (int i = 0; i < NR; i++) wrote[i] = written(i);
      for (int i = 1; i < NR; i++) begin
        mem[i] = eff(i);
        if (wrote[i]) pend[i] = 0;
        if (pend_set && int'(pend_addr) == i) pend[i] = 1;
      end
      exp_rs = n_rs; exp_rt = n_rt; exp_car = n_car;
    end
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; car_wr = 1'b0; pend_set = 1'b0;
    rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;
    car_data = '0; pend_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rd_en = 1'b1; rs_addr = 4'd3; rt_addr = 4'd11;
    #2;
    checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got rs=%b rt=%b want 0 0", rs_busy, rt_busy); end
    step();
    checks++; if (rs_out !== 8'h00 || rt_out !== 8'h00) begin errors++;
      $display("FAIL reset_read: got rs=%h rt=%h want 00 00", rs_out, rt_out); end
    checks++; if (car_out !== 8'h00) begin errors++;
      $display("FAIL reset_car: got %h want 00", car_out); end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
    step();
    idle(); rd_en = 1'b1; rs_addr = 4'd5; rt_addr = 4'd0;
    step();
    checks++; if (rs_out !== 8'hA5 || rt_out !== 8'h00) begin errors++;
      $display("FAIL write_read: got rs=%h rt=%h want a5 00", rs_out, rt_out); end
    idle(); wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h3C;
    step();
    idle(); rd_en = 1'b1; rs_addr = 4'd0; rt_addr = 4'd0;
    step();
    checks++; if (rs_out !== 8'h00 || rt_out !== 8'h00) begin errors++;
      $display("FAIL write_r0: got rs=%h rt=%h want 00 00", rs_out, rt_out); end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h5A;
    rd_en = 1'b1; rs_addr = 4'd7; rt_addr = 4'd7;
    step();
    checks++; if (rs_out !== 8'h5A || rt_out !== 8'h5A) begin errors++;
      $display("FAIL bypass: got rs=%h rt=%h want 5a 5a", rs_out, rt_out); end
    idle(); rs_addr = 4'd1; rt_addr = 4'd2;
    step();
    checks++; if (rs_out !== 8'h5A || rt_out !== 8'h5A) begin errors++;
      $display("FAIL hold: got rs=%h rt=%h want 5a 5a", rs_out, rt_out); end
  endtask

  task automatic test_car_conflict();
    idle();
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 8'h11;
    car_wr = 1'b1; car_data = 8'h22;
    step();
    checks++; if (car_out !== 8'h22) begin errors++;
      $display("FAIL car_conflict: got %h want 22", car_out); end
    idle(); rd_en = 1'b1; rs_addr = 4'd11; rt_addr = 4'd11;
    step();
    checks++; if (rs_out !== 8'h22 || rt_out !== 8'h22) begin errors++;
      $display("FAIL car_read: got rs=%h rt=%h want 22 22", rs_out, rt_out); end
  endtask

  task automatic test_scoreboard();
    idle(); pend_set = 1'b1; pend_addr = 4'd4;
    step();
    idle(); rs_addr = 4'd4; rt_addr = 4'd5;
    #2;
    checks++; if (rs_busy !== 1'b1 || rt_busy !== 1'b0) begin errors++;
      $display("FAIL sb_set: got rs=%b rt=%b want 1 0", rs_busy, rt_busy); end
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h77;
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++;
      $display("FAIL sb_write_comb: got %b want 0", rs_busy); end
    step();
    wr_en = 1'b0;
    #2;
    checks++; if (rs_busy !== 1'b0) begin errors++;
      $display("FAIL sb_cleared: got %b want 0", rs_busy); end
    pend_set = 1'b1; pend_addr = 4'd4; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h77;
    step();
    idle(); rs_addr = 4'd4;
    #2;
    checks++; if (rs_busy !== 1'b1) begin errors++;
      $display("FAIL sb_new_producer: got %b want 1", rs_busy); end
    pend_set = 1'b1; pend_addr = 4'd0;
    step();
    idle(); rs_addr = 4'd0; rt_addr = 4'd13;
    #2;
    checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin errors++;
      $display("FAIL sb_r0_oor: got rs=%b rt=%b want 0 0", rs_busy, rt_busy); end
  endtask

  task automatic test_mid_reset();
    idle(); rs_addr = 4'd4; rt_addr = 4'd4;
    #2;
    checks++; if (rs_busy !== 1'b1) begin errors++;
      $display("FAIL mid_pre: got %b want 1", rs_busy); end
    rst_n = 1'b0; rd_en = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h99;
    step();
    idle(); rd_en = 1'b1; rs_addr = 4'd4; rt_addr = 4'd11;
    #2;
    checks++; if (rs_busy !== 1'b0) begin errors++;
      $display("FAIL mid_busy: got %b want 0", rs_busy); end
    checks++; if (rs_out !== 8'h00 || car_out !== 8'h00) begin errors++;
      $display("FAIL mid_outs: got rs=%h car=%h want 00 00", rs_out, car_out); end
    step();
    checks++; if (rs_out !== 8'h00 || rt_out !== 8'h00) begin errors++;
      $display("FAIL mid_regs: got rs=%h rt=%h want 00 00", rs_out, rt_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      rd_en     = $urandom_range(0, 1);
      rs_addr   = AW'($urandom_range(0, 15));
      rt_addr   = AW'($urandom_range(0, 15));
      wr_en     = $urandom_range(0, 1);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = W'($urandom);
      car_wr    = ($urandom_range(0, 3) == 0);
      car_data  = W'($urandom);
      pend_set  = $urandom_range(0, 1);
      pend_addr = AW'($urandom_range(0, 15));
      #2;
      checks++;
      if (rs_busy !== busy_m(int'(rs_addr)) || rt_busy !== busy_m(int'(rt_addr))) begin
        errors++;
        $display("FAIL rand_busy[%0d]: got rs=%b rt=%b want %b %b", n,
                 rs_busy, rt_busy, busy_m(int'(rs_addr)), busy_m(int'(rt_addr)));
      end
      step();
      checks++;
      if (rs_out !== exp_rs || rt_out !== exp_rt || car_out !== exp_car) begin
        errors++;
        $display("FAIL rand_out[%0d]: got rs=%h rt=%h car=%h want %h %h %h", n,
                 rs_out, rt_out, car_out, exp_rs, exp_rt, exp_car);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin mem[i] = '0; pend[i] = 0; end
    idle();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_car_conflict();
    test_scoreboard();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
